rom_download_ctrl: RTL and testbench

ROM_DOWNLOAD_CTRL -- requirements
Module: rom_download_ctrl

---
 rtl/rom_download_ctrl.sv | 82 ++++++++
 tb/tb_rom_download_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rom_download_ctrl.sv
// rom_download_ctrl: buffers HPS ioctl download bytes into core ROM writes through a small FIFO
// and holds the game core in reset during and shortly after a download.
module rom_download_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [15:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        rom_wr,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    input  logic        rom_ready,
    output logic        core_reset,
    output logic        dn_busy,
    output logic        dn_overflow,
    output logic [15:0] byte_count,
    output logic [7:0]  checksum
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} state_t;
    state_t state, state_d;
    logic [7:0] hold_cnt, hold_cnt_d;
    logic dl_q, rise, clr, push_req, push, pop, full, empty;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [23:0] mem [FIFO_DEPTH];
    assign rise = ioctl_download & ~dl_q;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop = ~empty & rom_ready;
    assign push_req = (state == LOAD) && ioctl_wr;
    // a full FIFO still accepts when the head leaves in the same cycle
    assign push = push_req && (!full || pop);
    assign rom_wr = ~empty;
    assign {rom_addr, rom_data} = mem[rd_ptr[AW-1:0]];
    assign core_reset = state != IDLE;
    assign dn_busy = state != IDLE;
    assign clr = rise && state_d == LOAD;
    always_comb begin
        state_d = state;
        hold_cnt_d = hold_cnt;
        case (state)
            IDLE: state_d = rise ? LOAD : IDLE;
            LOAD: state_d = ioctl_download ? LOAD : DRAIN;
            DRAIN: begin
                state_d = rise ? LOAD : empty ? HOLD : DRAIN;
                hold_cnt_d = 8'(HOLD_CYCLES);
            end
            HOLD: begin
                state_d = rise ? LOAD : hold_cnt == 8'd1 ? IDLE : HOLD;
                hold_cnt_d = hold_cnt - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= HOLD;
            hold_cnt <= 8'(HOLD_CYCLES);
            dl_q <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            dn_overflow <= 1'b0;
            byte_count <= '0;
            checksum <= '0;
        end else begin
            state <= state_d;
            hold_cnt <= hold_cnt_d;
            dl_q <= ioctl_download;
            wr_ptr <= wr_ptr + {{AW{1'b0}}, push};
            rd_ptr <= rd_ptr + {{AW{1'b0}}, pop};
            dn_overflow <= clr ? 1'b0 : dn_overflow | (push_req & ~push);
            byte_count <= clr ? '0 : byte_count + {15'd0, push && byte_count != 16'hFFFF};
            checksum <= clr ? '0 : checksum + (push ? ioctl_dout : 8'd0);
        end
    end
    always_ff @(posedge clk_sys)
        if (push) mem[wr_ptr[AW-1:0]] <= {ioctl_addr, ioctl_dout};
endmodule

// File: tb/tb_rom_download_ctrl.sv
// tb_rom_download_ctrl: directed vectors for rom_download_ctrl with a write-capture scoreboard.
module tb_rom_download_ctrl;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [15:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        rom_ready = 1'b0;
    logic        rom_wr, core_reset, dn_busy, dn_overflow;
    logic [15:0] rom_addr, byte_count;
    logic [7:0]  rom_data, checksum;
    int vectors = 0;
    int miscompares = 0;
    int n;
    logic [23:0] wq[$];

    rom_download_ctrl #(.FIFO_DEPTH(4), .HOLD_CYCLES(16)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .rom_wr(rom_wr), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ready(rom_ready),
        .core_reset(core_reset), .dn_busy(dn_busy), .dn_overflow(dn_overflow),
        .byte_count(byte_count), .checksum(checksum)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys)
        if (rom_wr && rom_ready) wq.push_back({rom_addr, rom_data});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_byte(input logic [15:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic run_until_idle(output int cnt);
        cnt = 0;
        while (core_reset && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    task automatic run_until_empty(output int cnt);
        cnt = 0;
        while (rom_wr && cnt < 50) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        logic [23:0] exp3 [3];
        exp3[0] = 24'h000010;
        exp3[1] = 24'h000120;
        exp3[2] = 24'h0002F0;
        // reset state and power-up hold
        repeat (2) tick();
        check("rst_core_reset", core_reset, 1);
        check("rst_busy", dn_busy, 1);
        check("rst_rom_wr", rom_wr, 0);
        check("rst_overflow", dn_overflow, 0);
        check("rst_count", byte_count, 0);
        check("rst_checksum", checksum, 0);
        reset_n = 1'b1;
        run_until_idle(n);
        check("rel_hold_cycles", n, 16);
        check("rel_busy", dn_busy, 0);
        // three-byte download with an always-ready sink
        rom_ready = 1'b1;
        ioctl_download = 1'b1;
        tick();
        check("s2_core_reset", core_reset, 1);
        wr_byte(16'h0000, 8'h10);
        check("s2_latency_wr", rom_wr, 1);
        check("s2_latency_head", {rom_addr, rom_data}, 24'h000010);
        wr_byte(16'h0001, 8'h20);
        wr_byte(16'h0002, 8'hF0);
        ioctl_download = 1'b0;
        tick();
        check("s2_drained", rom_wr, 0);
        check("s2_count", byte_count, 3);
        check("s2_checksum", checksum, 8'h20);
        check("s2_nwrites", wq.size(), 3);
        for (int i = 0; i < 3; i++)
            check("s2_order", i < wq.size() ? wq[i] : 24'hXXXXXX, exp3[i]);
        run_until_idle(n);
        check("s2_drain_hold_cycles", n, 17);
        // stalled sink: six strobes into a four-entry FIFO
        wq.delete();
        rom_ready = 1'b0;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) wr_byte(16'h0100 + 16'(i), 8'hA0 + 8'(i));
        check("s3_count", byte_count, 4);
        check("s3_overflow", dn_overflow, 1);
        check("s3_checksum", checksum, 8'h86);
        check("s3_head_stable", {rom_wr, rom_addr, rom_data}, {1'b1, 24'h0100A0});
        rom_ready = 1'b1;
        ioctl_download = 1'b0;
        run_until_empty(n);
        check("s3_nwrites", wq.size(), 4);
        for (int i = 0; i < 4; i++)
            check("s3_order", i < wq.size() ? wq[i] : 24'hXXXXXX, {16'h0100 + 16'(i), 8'hA0 + 8'(i)});
        check("s3_overflow_sticky", dn_overflow, 1);
        run_until_idle(n);
        check("s3_idle", core_reset, 0);
        // re-rise of download in the middle of HOLD
        ioctl_download = 1'b1;
        tick();
        check("s4_overflow_cleared", dn_overflow, 0);
        wr_byte(16'h0200, 8'h55);
        ioctl_download = 1'b0;
        tick();
        tick();
        repeat (7) tick();
        check("s4_count_before", byte_count, 1);
        check("s4_checksum_before", checksum, 8'h55);
        ioctl_download = 1'b1;
        tick();
        check("s4_core_reset", core_reset, 1);
        check("s4_count_cleared", byte_count, 0);
        check("s4_checksum_cleared", checksum, 0);
        repeat (20) tick();
        check("s4_stays_load", core_reset, 1);
        // reset with two entries queued
        rom_ready = 1'b0;
        wr_byte(16'h0300, 8'h11);
        wr_byte(16'h0301, 8'h22);
        check("s5_queued", {rom_wr, byte_count}, {1'b1, 16'd2});
        reset_n = 1'b0;
        #1;
        check("s5_rom_wr_in_reset", rom_wr, 0);
        check("s5_count_in_reset", byte_count, 0);
        check("s5_core_reset", core_reset, 1);
        tick();
        tick();
        ioctl_download = 1'b0;
        rom_ready = 1'b1;
        wq.delete();
        reset_n = 1'b1;
        run_until_idle(n);
        check("s5_hold_cycles", n, 16);
        check("s5_no_writes", wq.size(), 0);
        // 300 bytes of 0xFF
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) wr_byte(16'(i), 8'hFF);
        ioctl_download = 1'b0;
        run_until_empty(n);
        check("s6_count", byte_count, 300);
        check("s6_checksum", checksum, 8'hD4);
        check("s6_nwrites", wq.size(), 300);
        check("s6_overflow", dn_overflow, 0);
        run_until_idle(n);
        check("s6_idle", dn_busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
